key_sched_iter: RTL and testbench

KEY_SCHED_ITER -- requirements
Module: key_sched_iter

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_sbox_word.sv | 16 +
 rtl/key_sched_iter.sv | 158 +++++++++++++++
 tb/tb_key_sched_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule: key-size encodings,
// FSM state type, Nk/Nr lookup, the forward S-box and GF(2^8) xtime.
package aes_pkg;

    localparam logic [1:0] MODE_AES128 = 2'b00;
    localparam logic [1:0] MODE_AES192 = 2'b01;
    localparam logic [1:0] MODE_AES256 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset (255 - x) * 8, which is {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Key length in words; the reserved encoding behaves as AES-128.
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_AES192: return 4'd6;
            MODE_AES256: return 4'd8;
            default:     return 4'd4;
        endcase
    endfunction

    // Number of rounds; round keys run from 0 to Nr.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_AES192: return 4'd12;
            MODE_AES256: return 4'd14;
            default:     return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word, purely combinational.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign dout[8*gi +: 8] = sbox(din[8*gi +: 8]);
        end
    endgenerate

endmodule

// File: rtl/key_sched_iter.sv
// Iterative AES key expansion: one schedule word per cycle, four words
// assembled into a round key that is handed out with a valid/ready handshake.
// Only the last eight words are kept, which covers w[i-1] and w[i-Nk].
module key_sched_iter
    import aes_pkg::*;
#(
    parameter int WORD_LEN = 32,
    parameter int KEY_MAX  = 256
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            key_mode,
    input  logic [KEY_MAX-1:0]    key_in,
    input  logic                  rk_ready,
    output logic                  rk_valid,
    output logic [4*WORD_LEN-1:0] round_key,
    output logic [3:0]            rk_index,
    output logic                  busy,
    output logic                  done
);

    localparam int W = WORD_LEN;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg;
    logic [KEY_MAX-1:0] key_reg;
    logic [5:0]       i_reg;
    logic [2:0]       k_reg;        // i mod Nk, kept as a counter to avoid a divider
    logic [3:0]       r_reg;
    logic [7:0]       rcon_reg;
    logic [W-1:0]     win_reg [0:7]; // win_reg[n] holds w[i-1-n]
    logic [W-1:0]     asm_reg [0:2];
    logic [1:0]       j_reg;        // word position inside the round key
    logic [4*W-1:0]   round_key_reg;
    logic             done_reg;

    logic [W-1:0]     key_words [0:7];
    logic [3:0]       nk, nr;
    logic [2:0]       nk_last;
    logic             in_key;
    logic [W-1:0]     prev_word, back_word, sub_in, sub_out, temp, new_word;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key_word
            assign key_words[gi] = key_reg[KEY_MAX-1-W*gi -: W];
        end
    endgenerate

    assign nk        = nk_of(mode_reg);
    assign nr        = nr_of(mode_reg);
    assign nk_last   = 3'(nk - 4'd1);
    assign in_key    = i_reg < {2'b00, nk};
    assign prev_word = win_reg[0];
    assign back_word = win_reg[nk_last];
    assign sub_in    = (k_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    // Single S-box word: RotWord+SubWord and the AES-256 mid-key SubWord never coincide.
    aes_sbox_word u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    // Next schedule word from the window, key register and Rcon.
    always_comb begin
        temp = prev_word;
        if (k_reg == 3'd0)
            temp = sub_out ^ {rcon_reg, 24'h000000};
        else if (nk == 4'd8 && k_reg == 3'd4)
            temp = sub_out;
        new_word = in_key ? key_words[k_reg] : (back_word ^ temp);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_EXPAND;
            ST_EXPAND: if (j_reg == 2'd3) state_next = ST_OUT;
            ST_OUT:    if (rk_ready) state_next = (r_reg == nr) ? ST_IDLE : ST_EXPAND;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        rk_valid  = (state_reg == ST_OUT);
        busy      = (state_reg != ST_IDLE);
        round_key = round_key_reg;
        rk_index  = r_reg;
        done      = done_reg;
    end

    // Datapath: key latch, window shift, assembler, Rcon and round counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg      <= '0;
            key_reg       <= '0;
            i_reg         <= '0;
            k_reg         <= '0;
            r_reg         <= '0;
            j_reg         <= '0;
            rcon_reg      <= 8'h01;
            round_key_reg <= '0;
            done_reg      <= 1'b0;
            for (int n = 0; n < 8; n++) win_reg[n] <= '0;
            for (int n = 0; n < 3; n++) asm_reg[n] <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mode_reg <= key_mode;
                        key_reg  <= key_in;
                        i_reg    <= '0;
                        k_reg    <= '0;
                        r_reg    <= '0;
                        j_reg    <= '0;
                        rcon_reg <= 8'h01;
                        for (int n = 0; n < 3; n++) asm_reg[n] <= '0;
                    end
                end
                ST_EXPAND: begin
                    for (int n = 7; n > 0; n--) win_reg[n] <= win_reg[n-1];
                    win_reg[0] <= new_word;
                    i_reg <= i_reg + 6'd1;
                    k_reg <= (k_reg == nk_last) ? 3'd0 : k_reg + 3'd1;
                    if (!in_key && k_reg == 3'd0)
                        rcon_reg <= xtime(rcon_reg);
                    if (j_reg == 2'd3)
                        round_key_reg <= {asm_reg[0], asm_reg[1], asm_reg[2], new_word};
                    else
                        asm_reg[j_reg] <= new_word;
                    j_reg <= j_reg + 2'd1;
                end
                ST_OUT: begin
                    if (rk_ready) begin
                        if (r_reg == nr)
                            done_reg <= 1'b1;
                        else
                            r_reg <= r_reg + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_sched_iter.sv
// Directed bench for key_sched_iter: FIPS-197 key expansion vectors for all
// key sizes, latency/throughput, backpressure, busy start and mid-run reset.
module tb_key_sched_iter;

    logic         clk = 1'b0;
    logic         reset, start, rk_ready;
    logic [1:0]   key_mode;
    logic [255:0] key_in;
    logic         rk_valid, busy, done;
    logic [127:0] round_key;
    logic [3:0]   rk_index;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] exp128 [0:10];
    logic [127:0] got     [0:15];
    logic [3:0]   got_idx [0:15];
    int           n_got, first_valid, done_cyc;

    always #5 clk = ~clk;

    key_sched_iter #(.WORD_LEN(32), .KEY_MAX(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_mode  (key_mode),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .rk_index  (rk_index),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the start edge T.
    task automatic launch(input logic [1:0] mode, input logic [255:0] key);
        key_mode = mode;
        key_in   = key;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc k is the falling edge after rising edge T+k. pattern 0: ready high;
    // pattern 1: random ready with a 20-cycle hold at round 3. mess: pulse start
    // and corrupt key_in/key_mode while busy.
    task automatic collect(input int pattern, input bit mess);
        int           hold;
        bit           held, last_stall, seen_done;
        logic [127:0] last_key;
        logic [3:0]   last_idx;
        n_got = 0; first_valid = -1; done_cyc = -1;
        hold = 0; held = 0; last_stall = 0; seen_done = 0;
        last_key = '0; last_idx = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done) begin
                done_cyc  = cyc;
                seen_done = 1'b1;
                break;
            end
            if (mess) begin
                if (cyc == 7) begin
                    start    = 1'b1;
                    key_in   = ~key_in;
                    key_mode = 2'b10;
                end else if (cyc == 10) begin
                    start = 1'b0;
                end
            end
            if (last_stall) begin
                chk("stall_valid", 128'(rk_valid), 128'd1);
                chk("stall_key", round_key, last_key);
                chk("stall_idx", 128'(rk_index), 128'(last_idx));
            end
            if (rk_valid && first_valid < 0) first_valid = cyc;
            if (pattern == 0) begin
                rk_ready = 1'b1;
            end else begin
                if (rk_valid && rk_index == 4'd3 && !held) begin
                    held = 1'b1;
                    hold = 20;
                end
                if (hold > 0) begin
                    rk_ready = 1'b0;
                    hold--;
                end else begin
                    rk_ready = 1'($urandom_range(0, 1));
                end
            end
            if (rk_valid && rk_ready) begin
                $display("round idx=%0d key=%h cyc=%0d", rk_index, round_key, cyc);
                if (n_got < 16) begin
                    got[n_got]     = round_key;
                    got_idx[n_got] = rk_index;
                end
                n_got++;
                last_stall = 1'b0;
            end else begin
                last_stall = rk_valid;
                last_key   = round_key;
                last_idx   = rk_index;
            end
        end
        chk("run_completes", 128'(seen_done), 128'd1);
    endtask

    task automatic check_seq128(input string tag);
        chk({tag, " count"}, 128'(n_got), 128'd11);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("%s r%0d", tag, k), got[k], exp128[k]);
            chk($sformatf("%s idx%0d", tag, k), 128'(got_idx[k]), 128'(k));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " rk_valid"},  128'(rk_valid), 128'd0);
        chk({tag, " busy"},      128'(busy), 128'd0);
        chk({tag, " done"},      128'(done), 128'd0);
        chk({tag, " round_key"}, round_key, 128'd0);
        chk({tag, " rk_index"},  128'(rk_index), 128'd0);
    endtask

    initial begin
        bit found;
        exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b0; start = 1'b0; rk_ready = 1'b0; key_mode = 2'b00; key_in = '0;
        #1;
        check_reset_outputs("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // AES-128, ready tied high: latency 4, done after T+55.
        launch(2'b00, KEY128);
        collect(0, 0);
        chk("a128 first_valid", 128'(first_valid), 128'd4);
        chk("a128 done_cycle", 128'(done_cyc), 128'd55);
        check_seq128("a128");
        @(negedge clk);
        chk("a128 done_one_cycle", 128'(done), 128'd0);
        chk("a128 idle_busy", 128'(busy), 128'd0);

        // Reserved mode behaves as AES-128.
        launch(2'b11, KEY128);
        collect(0, 0);
        chk("mode11 done_cycle", 128'(done_cyc), 128'd55);
        check_seq128("mode11");

        // AES-192, then AES-256 started in the cycle done is high.
        @(negedge clk);
        launch(2'b01, KEY192);
        collect(0, 0);
        chk("a192 count", 128'(n_got), 128'd13);
        chk("a192 done_cycle", 128'(done_cyc), 128'd65);
        chk("a192 r0", got[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        chk("a192 r1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        chk("a192 r12", got[12], 128'he98ba06f448c773c8ecc720401002202);
        chk("a192 idx12", 128'(got_idx[12]), 128'd12);

        launch(2'b10, KEY256);
        collect(0, 0);
        chk("a256 first_valid", 128'(first_valid), 128'd4);
        chk("a256 count", 128'(n_got), 128'd15);
        chk("a256 done_cycle", 128'(done_cyc), 128'd75);
        chk("a256 r0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
        chk("a256 r1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("a256 r2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("a256 r3", got[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        chk("a256 r14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("a256 idx14", 128'(got_idx[14]), 128'd14);

        // Backpressure: random ready plus a long hold at round 3.
        @(negedge clk);
        launch(2'b00, KEY128);
        collect(1, 0);
        check_seq128("bp");

        // start pulsed and key inputs changed while busy.
        @(negedge clk);
        launch(2'b00, KEY128);
        collect(0, 1);
        chk("busy_start done_cycle", 128'(done_cyc), 128'd55);
        check_seq128("busy_start");

        // Reset at round 5, then a fresh AES-128 run.
        @(negedge clk);
        launch(2'b00, KEY128);
        rk_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rk_valid && rk_index == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_r5", 128'(found), 128'd1);
        chk("r5 key_before_reset", round_key, exp128[5]);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        check_reset_outputs("mid_reset_held");
        reset = 1'b1;
        launch(2'b00, KEY128);
        collect(0, 0);
        chk("post_rst first_valid", 128'(first_valid), 128'd4);
        chk("post_rst done_cycle", 128'(done_cyc), 128'd55);
        check_seq128("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
